// File: rtl/bsg_gray_binary_pipe.sv
// Pipelined bidirectional Gray/binary converter with valid/ready in, valid/yumi out.
// Gray->binary prefix-XOR scan levels are spread across stages_p register stages.
module bsg_gray_binary_pipe #(
  parameter int width_p  = 16,
  parameter int stages_p = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic               dir_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic               dir_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int L     = $clog2(width_p);
  localparam int LastS = stages_p - 1;

  logic [stages_p-1:0] valid_q;
  logic [stages_p-1:0] dir_q;
  logic [stages_p-1:0] dir_d;
  logic [stages_p-1:0] adv;
  logic [stages_p-1:0] load;
  logic [width_p-1:0]  data_q [stages_p];
  logic [width_p-1:0]  data_d [stages_p];

  // Advance ripples back from the consumer so a full pipe still streams
  always_comb begin
    logic a;
    a = valid_q[LastS] & yumi_i;
    adv = '0;
    adv[LastS] = a;
    for (int s = LastS - 1; s >= 0; s--) begin
      a = valid_q[s] & (~valid_q[s+1] | a);
      adv[s] = a;
    end
  end

  assign ready_o = ~valid_q[0] | adv[0];

  always_comb begin
    load = '0;
    load[0] = v_i & ready_o;
    for (int s = 1; s < stages_p; s++) begin
      load[s] = adv[s-1];
    end
  end

  // Stage s applies scan levels floor(s*L/S) .. floor((s+1)*L/S)-1
  always_comb begin
    logic [width_p-1:0] t;
    logic               dr;
    t  = data_i;
    dr = dir_i;
    for (int s = 0; s < stages_p; s++) begin
      if (dr) begin
        if (s == 0) t = t ^ (t >> 1);
      end else begin
        for (int j = 0; j < L; j++) begin
          if (j >= (s * L) / stages_p && j < ((s + 1) * L) / stages_p)
            t = t ^ (t >> (1 << j));
        end
      end
      data_d[s] = t;
      dir_d[s]  = dr;
      t  = data_q[s];
      dr = dir_q[s];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= '0;
      dir_q   <= '0;
      for (int s = 0; s < stages_p; s++) data_q[s] <= '0;
    end else begin
      for (int s = 0; s < stages_p; s++) begin
        if (load[s]) begin
          valid_q[s] <= 1'b1;
          dir_q[s]   <= dir_d[s];
          data_q[s]  <= data_d[s];
        end else if (adv[s]) begin
          valid_q[s] <= 1'b0;
        end
      end
    end
  end

  assign v_o    = valid_q[LastS];
  assign dir_o  = dir_q[LastS];
  assign data_o = data_q[LastS];

endmodule

// File: tb/tb_bsg_gray_binary_pipe.sv
// Self-checking bench for bsg_gray_binary_pipe: directed cases on several
// configurations plus a randomized scoreboard run against a reference model.
module tb_bsg_gray_binary_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model straight from the code definitions
  function automatic logic [15:0] g2b(input logic [15:0] g, input int w);
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < w; k++) begin
      logic b;
      b = 1'b0;
      for (int m = k; m < w; m++) b = b ^ g[m];
      r[k] = b;
    end
    return r;
  endfunction

  function automatic logic [15:0] b2g(input logic [15:0] x, input int w);
    logic [15:0] m;
    m = 16'((32'd1 << w) - 1);
    return (x ^ (x >> 1)) & m;
  endfunction

  // width 16, 2 stages
  logic v16 = 0, dir16 = 0, yumi16 = 0, rdy16, vo16, diro16;
  logic [15:0] d16 = '0, do16;
  bsg_gray_binary_pipe #(.width_p(16), .stages_p(2)) dut16 (
    .clk_i(clk), .reset_i(rst), .v_i(v16), .dir_i(dir16), .data_i(d16),
    .ready_o(rdy16), .v_o(vo16), .dir_o(diro16), .data_o(do16), .yumi_i(yumi16));

  // width 8, 3 stages
  logic v8 = 0, dir8 = 0, yumi8 = 0, rdy8, vo8, diro8;
  logic [7:0] d8 = '0, do8;
  bsg_gray_binary_pipe #(.width_p(8), .stages_p(3)) dut8 (
    .clk_i(clk), .reset_i(rst), .v_i(v8), .dir_i(dir8), .data_i(d8),
    .ready_o(rdy8), .v_o(vo8), .dir_o(diro8), .data_o(do8), .yumi_i(yumi8));

  // width 5, 1 stage
  logic v5a = 0, dir5a = 0, yumi5a = 0, rdy5a, vo5a, diro5a;
  logic [4:0] d5a = '0, do5a;
  bsg_gray_binary_pipe #(.width_p(5), .stages_p(1)) dut5a (
    .clk_i(clk), .reset_i(rst), .v_i(v5a), .dir_i(dir5a), .data_i(d5a),
    .ready_o(rdy5a), .v_o(vo5a), .dir_o(diro5a), .data_o(do5a), .yumi_i(yumi5a));

  // width 5, 4 stages
  logic v5b = 0, dir5b = 0, yumi5b = 0, rdy5b, vo5b, diro5b;
  logic [4:0] d5b = '0, do5b;
  bsg_gray_binary_pipe #(.width_p(5), .stages_p(4)) dut5b (
    .clk_i(clk), .reset_i(rst), .v_i(v5b), .dir_i(dir5b), .data_i(d5b),
    .ready_o(rdy5b), .v_o(vo5b), .dir_o(diro5b), .data_o(do5b), .yumi_i(yumi5b));

  // yumi without a valid output is illegal
  always @(posedge clk) begin
    if (!rst) begin
      if (yumi16) chk("yumi16_legal", vo16, 1);
      if (yumi8)  chk("yumi8_legal", vo8, 1);
      if (yumi5a) chk("yumi5a_legal", vo5a, 1);
      if (yumi5b) chk("yumi5b_legal", vo5b, 1);
    end
  end

  logic [16:0] q16[$];

  // One cycle on dut16, entered and left at posedge+1
  task automatic cyc16(input logic v, input logic d, input logic [15:0] x,
                       input logic y, output logic acc);
    logic [16:0] e;
    v16 = v; dir16 = d; d16 = x; yumi16 = y & vo16;
    #2;
    acc = v & rdy16;
    if (vo16 && yumi16) begin
      if (q16.size() == 0) chk("q16_underflow", 1, 0);
      else begin
        e = q16.pop_front();
        chk("d16_data", do16, e[15:0]);
        chk("d16_dir", diro16, e[16]);
      end
    end
    if (acc) q16.push_back({d, d ? b2g(x, 16) : g2b(x, 16)});
    @(posedge clk); #1;
  endtask

  task automatic lat5(input bit sel, input logic dr, input logic [4:0] x,
                      input logic [4:0] e, input int lat);
    int n;
    if (sel) begin v5b = 1; dir5b = dr; d5b = x; end
    else begin v5a = 1; dir5a = dr; d5a = x; end
    @(posedge clk); #1;
    v5a = 0; v5b = 0;
    n = 0;
    while (!(sel ? vo5b : vo5a) && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk(sel ? "lat5b" : "lat5a", n, lat);
    chk(sel ? "d5b_data" : "d5a_data", sel ? do5b : do5a, e);
    chk(sel ? "d5b_dir" : "d5a_dir", sel ? diro5b : diro5a, dr);
    if (sel) yumi5b = 1; else yumi5a = 1;
    @(posedge clk); #1;
    yumi5a = 0; yumi5b = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic acc;
    logic [15:0] basic_in  [3];
    logic [15:0] basic_exp [3];
    logic        mix_dir   [4];
    logic [15:0] mix_dat   [4];
    logic [15:0] bp        [4];
    logic [15:0] held;
    int k, cyc, idx;
    logic [24:0] q8[$];
    logic [24:0] e8;
    logic        prev_hold;
    logic [8:0]  prev_out;

    basic_in  = '{16'h8000, 16'hC000, 16'h0001};
    basic_exp = '{16'hFFFF, 16'h8000, 16'h0001};
    mix_dir   = '{1'b1, 1'b0, 1'b1, 1'b0};
    mix_dat   = '{16'h00FF, 16'h0080, 16'h1234, 16'hA5C3};
    bp        = '{16'h0F0F, 16'h3C3C, 16'hFFFF, 16'h0002};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_v16", vo16, 0);
    chk("rst_d16", do16, 0);
    chk("rst_dir16", diro16, 0);
    chk("rst_v8", vo8, 0);
    chk("rst_v5b", vo5b, 0);
    rst = 0;
    #1;
    chk("rst_ready16", rdy16, 1);
    @(posedge clk); #1;

    // Basic Gray->binary with latency check
    for (int i = 0; i < 3; i++) begin
      v16 = 1; dir16 = 0; d16 = basic_in[i];
      #2;
      chk("basic_ready", rdy16, 1);
      @(posedge clk); #1;
      v16 = 0;
      chk("basic_early", vo16, 0);
      @(posedge clk); #1;
      chk("basic_v", vo16, 1);
      chk("basic_data", do16, basic_exp[i]);
      chk("basic_dir", diro16, 0);
      yumi16 = 1;
      @(posedge clk); #1;
      yumi16 = 0;
      chk("basic_gone", vo16, 0);
    end

    // Alternating directions at full rate
    for (int c = 0; c < 6; c++) begin
      if (c >= 2) chk("mix_vo", vo16, 1);
      cyc16(c < 4, c < 4 ? mix_dir[c] : 1'b0, c < 4 ? mix_dat[c] : 16'h0, 1, acc);
      if (c < 4) chk("mix_acc", acc, 1);
    end
    chk("mix_drained", q16.size(), 0);

    // Backpressure: capacity two, output held stable
    k = 0;
    held = '0;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) held = do16;
      if (c == 3) chk("bp_stable", do16, held);
      cyc16(1, 0, bp[k], 0, acc);
      if (acc) k++;
    end
    chk("bp_count", k, 2);
    chk("bp_ready_low", rdy16, 0);
    chk("bp_held", do16, g2b(bp[0], 16));
    yumi16 = 1;
    #1;
    chk("bp_ready_same_cycle", rdy16, 1);
    cyc = 0;
    while ((k < 4 || q16.size() != 0) && cyc < 20) begin
      cyc16(k < 4, 0, k < 4 ? bp[k] : 16'h0, 1, acc);
      if (acc) k++;
      cyc++;
    end
    chk("bp_all_in", k, 4);
    chk("bp_drained", q16.size(), 0);

    // Reset with two entries in flight
    cyc16(1, 0, 16'h1111, 0, acc);
    cyc16(1, 1, 16'h2222, 0, acc);
    chk("mid_full", vo16, 1);
    rst = 1; v16 = 1; dir16 = 1; d16 = 16'h3333; yumi16 = 0;
    @(posedge clk); #1;
    chk("mid_v", vo16, 0);
    chk("mid_data", do16, 0);
    chk("mid_dir", diro16, 0);
    rst = 0; v16 = 0;
    #1;
    chk("mid_ready", rdy16, 1);
    q16.delete();
    for (int c = 0; c < 4; c++) begin
      chk("mid_no_stale", vo16, 0);
      cyc16(0, 0, 16'h0, 1, acc);
    end

    // Odd width, 1 and 4 stages
    lat5(0, 0, 5'b10000, 5'b11111, 0);
    lat5(0, 1, 5'b10110, 5'b11101, 0);
    lat5(1, 0, 5'b10000, 5'b11111, 3);
    lat5(1, 1, 5'b10110, 5'b11101, 3);

    // All 8-bit values both ways, random valid and yumi
    idx = 0;
    cyc = 0;
    prev_hold = 0;
    prev_out = '0;
    while ((idx < 512 || q8.size() != 0) && cyc < 20000) begin
      if (prev_hold) chk("r8_stable", {diro8, do8}, prev_out);
      v8    = (idx < 512) && ($urandom_range(0, 9) < 7);
      dir8  = idx[0];
      d8    = 8'(idx >> 1);
      yumi8 = vo8 && ($urandom_range(0, 9) < 7);
      #2;
      if (vo8 && yumi8) begin
        if (q8.size() == 0) chk("r8_underflow", 1, 0);
        else begin
          e8 = q8.pop_front();
          chk("r8_data", do8, e8[15:8]);
          chk("r8_dir", diro8, e8[16]);
          if (e8[16]) chk("r8_round", g2b({8'h0, do8}, 8), e8[7:0]);
          else        chk("r8_round", b2g({8'h0, do8}, 8), e8[7:0]);
        end
      end
      if (v8 && rdy8) begin
        q8.push_back({8'h0, dir8,
                      8'(dir8 ? b2g({8'h0, d8}, 8) : g2b({8'h0, d8}, 8)), d8});
        idx++;
      end
      prev_hold = vo8 && !yumi8;
      prev_out  = {diro8, do8};
      @(posedge clk); #1;
      cyc++;
    end
    v8 = 0; yumi8 = 0;
    chk("r8_timeout", cyc < 20000, 1);
    chk("r8_all_sent", idx, 512);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bsg_gray_binary_pipe.md
# bsg_gray_binary_pipe

Parametrised, pipelined, bidirectional Gray/binary code converter with valid/ready input and valid/yumi output handshakes. Each transaction carries a direction bit selecting Gray→binary (prefix-XOR scan) or binary→Gray (adjacent XOR). The log2 scan levels are spread across `stages_p` register stages, so wide counters crossing clock-domain boundaries can be converted at speed. It sits after async-FIFO pointer synchronisers and before counter-compare logic.

## Interface
- `width_p`, 16, data width in bits; any value ≥1, not restricted to powers of two.
- `stages_p`, 2, number of register stages; ≥1.
  - Values above `L = $clog2(width_p)` add pass-through stages.
- `clk_i`  in  1  clock.
- `reset_i`  in  1  reset; synchronous, active-high.
- `v_i`  in  1  input valid.
- `dir_i`  in  1  0 = Gray→binary, 1 = binary→Gray.
- `data_i`  in  width_p  value to convert.
- `ready_o`  out  1  input accepted when `v_i & ready_o`.
- `v_o`  out  1  output valid.
- `dir_o`  out  1  direction of the presented result.
- `data_o`  out  width_p  converted value.
- `yumi_i`  in  1  consumer takes output. Legal only when `v_o=1`.

## Operation
- **Pipeline registers.** Stage s (0..stages_p-1) holds a register set `{valid_s, dir_s, data_s}`.
  - The last stage drives `v_o`, `dir_o` and `data_o`.
- **Gray→binary.** `out[k]` = XOR of `in[width_p-1:k]`. This is implemented as a Kogge-Stone scan:
  - Level j computes `t[k] ^= t[k+2^j]` for j = 0..L-1.
  - Terms with `k+2^j ≥ width_p` use 0.
- **Level-to-stage mapping.** Stage s performs levels `floor(s*L/stages_p)` through `floor((s+1)*L/stages_p)-1`.
  - A stage with an empty range passes data through unchanged.
  - If `width_p=1`, then L=0 and every stage passes through.
- **Binary→Gray.** Stage 0 computes `in ^ (in >> 1)`; all later stages pass through.
  - Each stage applies a scan level only when its `dir_s=0`.
- **Stage advance.** Stage s advances when `valid_s & (stage s+1 empty or stage s+1 advancing)`.
  - For the last stage, "advancing" means `yumi_i`.
  - Bubbles collapse: any empty stage accepts new data.
- **Ready.** `ready_o = ~valid_0 | advance_0`. This is combinational from `yumi_i` through the advance chain.
  - `ready_o` does not depend on `v_i`.
- **Simultaneous accept and drain.** A full pipeline accepts a new input in the same cycle that `yumi_i` drains the output, sustaining 1 transaction per cycle.
- **Ordering.** Results leave strictly in acceptance order; there is no reordering and no drop.
- **Non-advancing stage.** A stage that does not advance holds `dir_s` and `data_s` stable.
  - Outputs are stable while `v_o=1 & ~yumi_i`.
- **Direction changes.** Direction may change every transaction and needs no flush.
- **Illegal yumi.** `yumi_i` while `v_o=0` is illegal; the bench asserts against it. The RTL ignores it.

## Timing
- **Reset values.** In the cycle after `reset_i` is sampled high:
  - all `valid_s`=0, `v_o`=0, `dir_o`=0, `data_o`=0.
  - `ready_o`=1 from the first cycle after reset deasserts.
- **Reset mid-operation.** Reset during operation discards all in-flight transactions. Inputs presented while `reset_i`=1 are not accepted.
- **Latency.** Data accepted at clock edge n appears on `v_o` in cycle n+stages_p-1 when unstalled. With `stages_p=1`, the result is visible the cycle after acceptance.
- **Throughput.** 1 per cycle while `yumi_i` is held high.
- **Capacity.** The pipeline holds exactly `stages_p` entries.
  - With `yumi_i`=0, `ready_o` drops after `stages_p` accepts.
  - It rises in the same cycle `yumi_i` asserts.
- **Combinational paths.** The only combinational path is `yumi_i`→`ready_o`. There is no path from `v_i` or `data_i` to any output.

## Test plan
- **Basic conversions.** width_p=16, stages_p=2, Gray→binary:
  - `data_i`=16'h8000 → `data_o`=16'hFFFF.
  - 16'hC000 → 16'h8000.
  - 16'h0001 → 16'h0001.
  - Each result appears 1 cycle after acceptance with `yumi_i`=1.
- **Direction mix.** Back-to-back transactions alternating `dir_i`:
  - binary 16'h00FF → Gray 16'h0080.
  - Gray 16'h0080 → binary 16'h00FF.
  - Expect `dir_o` matching each, throughput 1 per cycle, order preserved.
- **Backpressure.** Hold `yumi_i`=0 and stream 4 inputs.
  - Exactly 2 are accepted, then `ready_o`=0 and `data_o` is held stable.
  - Raise `yumi_i`: `ready_o`=1 in the same cycle, and all results drain in order.
- **Reset mid-flight.** Reset with 2 entries in flight.
  - Next cycle: `v_o`=0, `data_o`=0, `ready_o`=1.
  - No stale result ever appears.
- **Odd width.** width_p=5, stages_p=1 and stages_p=4:
  - Gray 5'b10000 → 5'b11111.
  - binary 5'b10110 → Gray 5'b11101.
  - Latency is 0 and 3 cycles respectively (edges after acceptance).
- **Exhaustive random.** width_p=8, stages_p=3, all 256 values in both directions with random `v_i` and `yumi_i`.
  - Output matches a golden model, and the round trip returns the original value.
